// File: rtl/phys_reg_release_queue_pkg.sv
// phys_reg_release_queue_pkg: shared types and sizing for the physical-register release queue
package phys_reg_release_queue_pkg;
    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int PHYS_ADDR_W = $clog2(NUM_PHYS_REGS);
    typedef logic [PHYS_ADDR_W-1:0] phys_addr_t;
    typedef enum logic [1:0] {WAIT, INIT, RUN} release_state_t;
endpackage

// File: rtl/phys_reg_release_queue_if.sv
// phys_reg_release_queue_if: retire-side release requests and free-list producer signals
// master: the release queue (drives release_ready and fl_*); slave: retire unit / free list
interface phys_reg_release_queue_if;
    import phys_reg_release_queue_pkg::*;
    logic [1:0] retire_valid;
    phys_addr_t [1:0] retire_phys_addr;
    logic release_ready;
    logic fl_full;
    logic fl_pop;
    logic fl_potential_push;
    logic fl_push;
    phys_addr_t fl_data;
    modport master (
        input retire_valid, retire_phys_addr, fl_full, fl_pop,
        output release_ready, fl_potential_push, fl_push, fl_data
    );
    modport slave (
        output retire_valid, retire_phys_addr, fl_full, fl_pop,
        input release_ready, fl_potential_push, fl_push, fl_data
    );
endinterface

// File: rtl/phys_reg_release_queue_release_buffer_2w1r.sv
// phys_reg_release_queue_release_buffer_2w1r: 2-write/1-read circular buffer of physical register IDs
// ports: clk, rst (async, active-high); wr_en/wr_data per lane (lane0 written first);
//        rd_en pops head; rd_data shows head; count is occupancy
module phys_reg_release_queue_release_buffer_2w1r
    import phys_reg_release_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input logic clk,
    input logic rst,
    input logic [1:0] wr_en,
    input phys_addr_t [1:0] wr_data,
    input logic rd_en,
    output phys_addr_t rd_data,
    output logic [CW-1:0] count
);
    phys_addr_t mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [1:0] n;
    assign n = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};
    assign rd_data = mem[head];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            head <= head + AW'(rd_en);
            tail <= tail + AW'(n);
            count <= count + CW'(n) - CW'(rd_en);
        end
    end
    // lane1 lands behind lane0 only when lane0 was also accepted
    always_ff @(posedge clk) begin
        if (wr_en[0]) mem[tail] <= wr_data[0];
        if (wr_en[1]) mem[tail + AW'(wr_en[0])] <= wr_data[1];
    end
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        {1'b0, count} + (CW+1)'(n) <= (CW+1)'(DEPTH));
endmodule

// File: rtl/phys_reg_release_queue.sv
// phys_reg_release_queue: seeds the free list after reset, then drains retired physical registers into it
// ports: clk, rst (async, active-high); bus (master modport: retire requests in, free-list push out);
//        init_done, queue_count, release_count (counts RUN pushes only with PHYS_RELEASE_STATS_EN defined)
module phys_reg_release_queue
    import phys_reg_release_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 8,
    localparam int CW = $clog2(QUEUE_DEPTH) + 1
) (
    input logic clk,
    input logic rst,
    phys_reg_release_queue_if.master bus,
    output logic init_done,
    output logic [CW-1:0] queue_count,
    output logic [31:0] release_count
);
    release_state_t state, state_next;
    phys_addr_t seed, rd_data;
    logic can_push, push, in_init, in_run;
    logic [1:0] accept;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT;
            seed <= phys_addr_t'(NUM_ARCH_REGS);
            init_done <= 1'b0;
        end else begin
            state <= state_next;
            init_done <= state_next == RUN;
            if (in_init && push) seed <= seed + phys_addr_t'(1);
        end
    end
    always_comb begin
        state_next = (state == WAIT) ? INIT :
                     (in_init && push && seed == phys_addr_t'(NUM_PHYS_REGS - 1)) ? RUN : state;
    end
    // a same-cycle pop frees a slot, so a full free list can still take a push
    always_comb begin
        in_init = state == INIT;
        in_run = state == RUN;
        can_push = ~bus.fl_full | bus.fl_pop;
        bus.release_ready = in_run && queue_count <= CW'(QUEUE_DEPTH - 2);
        for (int i = 0; i < 2; i++)
            accept[i] = bus.release_ready & bus.retire_valid[i] & (|bus.retire_phys_addr[i]);
        push = in_init ? can_push : in_run & (|queue_count) & can_push;
        bus.fl_push = push;
        bus.fl_potential_push = push;
        bus.fl_data = in_init ? seed : in_run ? rd_data : '0;
    end
    phys_reg_release_queue_release_buffer_2w1r #(.DEPTH(QUEUE_DEPTH)) buffer (
        .clk(clk),
        .rst(rst),
        .wr_en(accept),
        .wr_data(bus.retire_phys_addr),
        .rd_en(in_run & push),
        .rd_data(rd_data),
        .count(queue_count)
    );
`ifdef PHYS_RELEASE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) release_count <= '0;
        else if (in_run && push && ~&release_count) release_count <= release_count + 32'd1;
    end
`else
    assign release_count = '0;
`endif
    a_push_room: assert property (@(posedge clk) disable iff (rst) push |-> can_push);
    a_retire_ready: assert property (@(posedge clk) disable iff (rst)
        (|bus.retire_valid) |-> bus.release_ready);
endmodule

// File: tb/tb_phys_reg_release_queue.sv
// tb_phys_reg_release_queue: directed vectors for the physical-register release queue
module tb_phys_reg_release_queue;
    import phys_reg_release_queue_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_done;
    logic [3:0] queue_count;
    logic [31:0] release_count;
    int n_vec = 0;
    int n_bad = 0;
    phys_reg_release_queue_if bus ();
    phys_reg_release_queue #(.QUEUE_DEPTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .init_done(init_done),
        .queue_count(queue_count),
        .release_count(release_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic retire(input logic [1:0] v, input int a0, input int a1);
        bus.retire_valid = v;
        bus.retire_phys_addr[0] = phys_addr_t'(a0);
        bus.retire_phys_addr[1] = phys_addr_t'(a1);
        @(negedge clk);
        bus.retire_valid = 2'b00;
    endtask
    task automatic seed_run(input bit stall);
        int got = 0;
        int exp = 32;
        int cyc = 0;
        bit stalled = 0;
        while (got < 32 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (stall && !stalled && exp == 41) begin
                stalled = 1;
                bus.fl_full = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    #1;
                    chk("stall_push", 32'(bus.fl_push), 0);
                    chk("stall_data", 32'(bus.fl_data), 41);
                end
                bus.fl_full = 1'b0;
                #1;
            end
            if (bus.fl_push) begin
                chk("seed_data", 32'(bus.fl_data), 32'(exp));
                chk("seed_potential", 32'(bus.fl_potential_push), 1);
                chk("seed_init_low", 32'(init_done), 0);
                exp++;
                got++;
            end
        end
        chk("seed_total", 32'(got), 32);
        @(negedge clk);
        chk("init_done", 32'(init_done), 1);
        chk("run_idle_push", 32'(bus.fl_push), 0);
        chk("run_ready", 32'(bus.release_ready), 1);
    endtask
    initial begin
        bus.retire_valid = 2'b00;
        bus.retire_phys_addr = '0;
        bus.fl_full = 1'b0;
        bus.fl_pop = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_push", 32'(bus.fl_push), 0);
        chk("rst_potential", 32'(bus.fl_potential_push), 0);
        chk("rst_data", 32'(bus.fl_data), 0);
        chk("rst_ready", 32'(bus.release_ready), 0);
        chk("rst_count", 32'(queue_count), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_rel_count", release_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("wait_no_push", 32'(bus.fl_push), 0);
        seed_run(0);
        bus.retire_valid = 2'b11;
        bus.retire_phys_addr[0] = phys_addr_t'(40);
        bus.retire_phys_addr[1] = phys_addr_t'(41);
        #1 chk("no_bypass", 32'(bus.fl_push), 0);
        @(negedge clk);
        bus.retire_valid = 2'b00;
        chk("pair_count2", 32'(queue_count), 2);
        chk("pair_push0", 32'(bus.fl_push), 1);
        chk("pair_data0", 32'(bus.fl_data), 40);
        @(negedge clk);
        chk("pair_count1", 32'(queue_count), 1);
        chk("pair_data1", 32'(bus.fl_data), 41);
        @(negedge clk);
        chk("pair_count0", 32'(queue_count), 0);
        chk("pair_idle", 32'(bus.fl_push), 0);
        retire(2'b11, 0, 45);
        chk("x0_count", 32'(queue_count), 1);
        chk("x0_data", 32'(bus.fl_data), 45);
        @(negedge clk);
        chk("x0_drained", 32'(queue_count), 0);
        bus.fl_full = 1'b1;
        retire(2'b11, 1, 2);
        chk("fill_count2", 32'(queue_count), 2);
        retire(2'b11, 3, 4);
        retire(2'b11, 5, 6);
        chk("fill_count6", 32'(queue_count), 6);
        chk("fill_ready6", 32'(bus.release_ready), 1);
        retire(2'b01, 7, 0);
        chk("fill_count7", 32'(queue_count), 7);
        chk("fill_ready7", 32'(bus.release_ready), 0);
        chk("full_no_push", 32'(bus.fl_push), 0);
        bus.fl_pop = 1'b1;
        #1;
        chk("pop_push", 32'(bus.fl_push), 1);
        chk("pop_data", 32'(bus.fl_data), 1);
        @(negedge clk);
        chk("pop_count6", 32'(queue_count), 6);
        chk("pop_ready6", 32'(bus.release_ready), 1);
        chk("pop_data2", 32'(bus.fl_data), 2);
        @(negedge clk);
        bus.fl_pop = 1'b0;
        #1;
        chk("pop_count5", 32'(queue_count), 5);
        chk("full_hold", 32'(bus.fl_push), 0);
`ifdef PHYS_RELEASE_STATS_EN
        chk("rel_count", release_count, 5);
`else
        chk("rel_count", release_count, 0);
`endif
        #1 rst = 1'b1;
        #1;
        chk("arst_count", 32'(queue_count), 0);
        chk("arst_push", 32'(bus.fl_push), 0);
        chk("arst_data", 32'(bus.fl_data), 0);
        chk("arst_ready", 32'(bus.release_ready), 0);
        chk("arst_init_done", 32'(init_done), 0);
        bus.fl_full = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rewait_no_push", 32'(bus.fl_push), 0);
        seed_run(1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
